// File: rtl/neureka_tcdm_split_collect_pkg.sv
// Shared definitions for the NEUREKA wide-to-TCDM splitter/collector.
package neureka_package;

  localparam int unsigned NEUREKA_TCDM_PORT_W = 32;

  typedef enum logic {
    IDLE,
    ISSUE
  } tcdm_split_state_e;

endpackage

// File: rtl/neureka_tcdm_split_collect_port_slice.sv
// Per-port issue/collect state: outstanding grant, outstanding read response,
// captured read data and detection of responses that match no pending read.
module neureka_tcdm_port_slice
  import neureka_package::*;
(
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           idle_i,
  input  logic                           w_req_i,
  input  logic                           rd_i,
  input  logic                           gnt_i,
  input  logic                           r_valid_i,
  input  logic [NEUREKA_TCDM_PORT_W-1:0] r_data_i,
  output logic                           req_o,
  output logic                           pend_o,
  output logic                           rpend_o,
  output logic                           err_o,
  output logic [NEUREKA_TCDM_PORT_W-1:0] rbuf_o
);

  logic                           pend_q, pend_d;
  logic                           rpend_q, rpend_d;
  logic [NEUREKA_TCDM_PORT_W-1:0] rbuf_q, rbuf_d;

  always_comb begin
    req_o   = rst_ni & (idle_i ? w_req_i : pend_q);
    pend_d  = idle_i ? (w_req_i & ~gnt_i) : (pend_q & ~gnt_i);
    // The response of an older grant clears while a new grant may set it again.
    rpend_d = (rpend_q & ~r_valid_i) | (req_o & gnt_i & rd_i);
    rbuf_d  = (r_valid_i & rpend_q) ? r_data_i : rbuf_q;
    err_o   = r_valid_i & ~rpend_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q  <= 1'b0;
      rpend_q <= 1'b0;
      rbuf_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      rpend_q <= rpend_d;
      rbuf_q  <= rbuf_d;
    end
  end

  assign pend_o  = pend_q;
  assign rpend_o = rpend_q;
  assign rbuf_o  = rbuf_q;

endmodule

// File: rtl/neureka_tcdm_split_collect.sv
// Splits a wide TCDM request into MP independently granted 32-bit ports and
// re-assembles per-port read responses into one wide response.
module neureka_tcdm_split_collect
  import neureka_package::*;
#(
  parameter int unsigned MP = 9,
  parameter int unsigned BW = MP * NEUREKA_TCDM_PORT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              w_req,
  output logic              w_gnt,
  input  logic [31:0]       w_add,
  input  logic              w_wen,
  input  logic [BW/8-1:0]   w_be,
  input  logic [BW-1:0]     w_data,
  output logic [BW-1:0]     w_r_data,
  output logic              w_r_valid,
  output logic [MP-1:0]     tcdm_req,
  input  logic [MP-1:0]     tcdm_gnt,
  output logic [MP*32-1:0]  tcdm_add,
  output logic [MP-1:0]     tcdm_wen,
  output logic [MP*4-1:0]   tcdm_be,
  output logic [MP*32-1:0]  tcdm_data,
  input  logic [MP*32-1:0]  tcdm_r_data,
  input  logic [MP-1:0]     tcdm_r_valid,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned PW = NEUREKA_TCDM_PORT_W;

  tcdm_split_state_e state_q, state_d;
  logic [31:0]       add_q;
  logic              wen_q;
  logic [BW/8-1:0]   be_q;
  logic [BW-1:0]     data_q;
  logic              err_q;

  logic              idle;
  logic              eff_wen;
  logic [MP-1:0]     pend, rpend, err_vec;
  logic [MP-1:0][PW-1:0] rbuf;

  assign idle    = (state_q == IDLE);
  assign eff_wen = idle ? w_wen : wen_q;

  for (genvar g = 0; g < MP; g++) begin : g_port
    neureka_tcdm_port_slice u_slice (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .idle_i    (idle),
      .w_req_i   (w_req),
      .rd_i      (eff_wen),
      .gnt_i     (tcdm_gnt[g]),
      .r_valid_i (tcdm_r_valid[g]),
      .r_data_i  (tcdm_r_data[g*PW +: PW]),
      .req_o     (tcdm_req[g]),
      .pend_o    (pend[g]),
      .rpend_o   (rpend[g]),
      .err_o     (err_vec[g]),
      .rbuf_o    (rbuf[g])
    );
  end

  always_comb begin
    tcdm_add  = '0;
    tcdm_wen  = '0;
    tcdm_be   = '0;
    tcdm_data = '0;
    w_gnt     = 1'b0;
    w_r_valid = 1'b0;
    w_r_data  = '0;
    state_d   = state_q;
    if (rst_ni) begin
      for (int unsigned i = 0; i < MP; i++) begin
        tcdm_add[i*PW +: PW] = (idle ? w_add : add_q) + 32'(i * 4);
      end
      tcdm_wen  = {MP{eff_wen}};
      tcdm_be   = idle ? w_be : be_q;
      tcdm_data = idle ? w_data : data_q;
      w_gnt     = idle ? (w_req & (&tcdm_gnt)) : (&(~pend | tcdm_gnt));
      // Only complete once issuing has finished, so earlier-granted ports
      // responding alone never fire the wide response.
      w_r_valid = idle & (|rpend) & ~(|(rpend & ~tcdm_r_valid));
      if (w_r_valid) begin
        for (int unsigned i = 0; i < MP; i++) begin
          w_r_data[i*PW +: PW] = (rpend[i] & tcdm_r_valid[i]) ? tcdm_r_data[i*PW +: PW] : rbuf[i];
        end
      end
      if (idle && w_req && !(&tcdm_gnt)) state_d = ISSUE;
      else if (!idle && w_gnt)           state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      add_q   <= '0;
      wen_q   <= 1'b0;
      be_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (idle && w_req) begin
        add_q  <= w_add;
        wen_q  <= w_wen;
        be_q   <= w_be;
        data_q <= w_data;
      end
      err_q <= err_q | (|err_vec);
    end
  end

  assign busy_o = ~idle | (|rpend);
  assign err_o  = err_q;

endmodule

// File: tb/tb_neureka_tcdm_split_collect.sv
// Directed bench for neureka_tcdm_split_collect with a one-cycle TCDM responder.
module tb_neureka_tcdm_split_collect;

  localparam int MP = 9;
  localparam int BW = MP * 32;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            w_req, w_gnt, w_wen, w_r_valid;
  logic [31:0]     w_add;
  logic [BW/8-1:0] w_be;
  logic [BW-1:0]   w_data, w_r_data;
  logic [MP-1:0]   tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
  logic [MP*32-1:0] tcdm_add, tcdm_data, tcdm_r_data;
  logic [MP*4-1:0] tcdm_be;
  logic            busy_o, err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  neureka_tcdm_split_collect #(.MP(MP)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .w_req        (w_req),
    .w_gnt        (w_gnt),
    .w_add        (w_add),
    .w_wen        (w_wen),
    .w_be         (w_be),
    .w_data       (w_data),
    .w_r_data     (w_r_data),
    .w_r_valid    (w_r_valid),
    .tcdm_req     (tcdm_req),
    .tcdm_gnt     (tcdm_gnt),
    .tcdm_add     (tcdm_add),
    .tcdm_wen     (tcdm_wen),
    .tcdm_be      (tcdm_be),
    .tcdm_data    (tcdm_data),
    .tcdm_r_data  (tcdm_r_data),
    .tcdm_r_valid (tcdm_r_valid),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] resp(input logic [31:0] a);
    return a ^ 32'hC3C3_5A5A;
  endfunction

  function automatic logic [BW-1:0] exp_add(input logic [31:0] base);
    logic [BW-1:0] v;
    for (int i = 0; i < MP; i++) v[i*32 +: 32] = base + 32'(4 * i);
    return v;
  endfunction

  function automatic logic [BW-1:0] exp_rd(input logic [31:0] base);
    logic [BW-1:0] v;
    for (int i = 0; i < MP; i++) v[i*32 +: 32] = resp(base + 32'(4 * i));
    return v;
  endfunction

  // Advance one cycle; ports granted for a read answer on the following cycle.
  task automatic step();
    logic [MP-1:0]    m;
    logic [MP*32-1:0] a;
    m = tcdm_req & tcdm_gnt & tcdm_wen;
    a = tcdm_add;
    @(posedge clk);
    #1;
    tcdm_r_valid = m;
    for (int i = 0; i < MP; i++) tcdm_r_data[i*32 +: 32] = resp(a[i*32 +: 32]);
  endtask

  logic [31:0]   base;
  logic [BW-1:0] wd;
  logic [BW-1:0] q[$];
  int            issued, got;

  initial begin
    rst_ni = 1'b0; w_req = 1'b0; w_wen = 1'b0; w_add = '0; w_be = '0; w_data = '0;
    tcdm_gnt = '0; tcdm_r_valid = '0; tcdm_r_data = '0;
    step(); step(); #3;
    check("rst_req",   BW'(tcdm_req), BW'(0));
    check("rst_outs",  BW'({w_gnt, w_r_valid, busy_o, err_o}), BW'(0));
    step(); rst_ni = 1'b1; #3;
    check("rst_rdata", w_r_data, '0);
    check("rst_busy",  BW'(busy_o), BW'(0));

    // All ports grant at once
    base = 32'h1000_0000;
    step(); w_req = 1'b1; w_wen = 1'b1; w_add = base; tcdm_gnt = 9'h1FF; #3;
    check("t1_gnt",   BW'(w_gnt), BW'(1));
    check("t1_req",   BW'(tcdm_req), BW'(9'h1FF));
    check("t1_add",   tcdm_add, exp_add(base));
    check("t1_add8",  BW'(tcdm_add[287:256]), BW'(32'h1000_0020));
    step(); w_req = 1'b0; tcdm_gnt = '0; #3;
    check("t1_rvalid", BW'(w_r_valid), BW'(1));
    check("t1_rdata",  w_r_data, exp_rd(base));
    check("t1_busy",   BW'(busy_o), BW'(1));
    step(); #3;
    check("t1_rvalid_end", BW'(w_r_valid), BW'(0));
    check("t1_idle",       BW'(busy_o), BW'(0));

    // Staggered grants: 0-3 in cycle 0, 4-7 in cycle 2, 8 in cycle 5
    base = 32'h1000_0100;
    step(); w_req = 1'b1; w_wen = 1'b1; w_add = base; tcdm_gnt = 9'h00F; #3;
    check("t2_c0_gnt", BW'(w_gnt), BW'(0));
    check("t2_c0_req", BW'(tcdm_req), BW'(9'h1FF));
    step(); w_req = 1'b0; w_add = 32'hDEAD_BEEF; tcdm_gnt = '0; #3;
    check("t2_c1_req",  BW'(tcdm_req), BW'(9'h1F0));
    check("t2_c1_add4", BW'(tcdm_add[159:128]), BW'(32'h1000_0110));
    check("t2_c1_rv",   BW'(w_r_valid), BW'(0));
    check("t2_c1_busy", BW'(busy_o), BW'(1));
    step(); tcdm_gnt = 9'h0F0; #3;
    check("t2_c2_req", BW'(tcdm_req), BW'(9'h1F0));
    check("t2_c2_gnt", BW'(w_gnt), BW'(0));
    step(); tcdm_gnt = '0; #3;
    check("t2_c3_req", BW'(tcdm_req), BW'(9'h100));
    check("t2_c3_rv",  BW'(w_r_valid), BW'(0));
    step(); #3;
    check("t2_c4_gnt", BW'(w_gnt), BW'(0));
    step(); tcdm_gnt = 9'h100; #3;
    check("t2_c5_gnt", BW'(w_gnt), BW'(1));
    step(); tcdm_gnt = '0; #3;
    check("t2_c6_rv",    BW'(w_r_valid), BW'(1));
    check("t2_c6_rdata", w_r_data, exp_rd(base));
    check("t2_c6_req",   BW'(tcdm_req), BW'(0));
    step(); #3;
    check("t2_c7_rv",   BW'(w_r_valid), BW'(0));
    check("t2_c7_busy", BW'(busy_o), BW'(0));

    // Write with alternating byte-enable nibbles
    for (int i = 0; i < MP; i++) wd[i*32 +: 32] = 32'h1111_1111 * 32'(i + 1);
    step(); w_req = 1'b1; w_wen = 1'b0; w_add = 32'h4000_0000;
    w_be = 36'h0F0F0F0F0; w_data = wd; tcdm_gnt = 9'h1FF; #3;
    check("t3_gnt",  BW'(w_gnt), BW'(1));
    check("t3_wen",  BW'(tcdm_wen), BW'(0));
    check("t3_be",   BW'(tcdm_be), BW'(36'h0F0F0F0F0));
    check("t3_be1",  BW'(tcdm_be[7:4]), BW'(4'hF));
    check("t3_dat2", BW'(tcdm_data[95:64]), BW'(32'h3333_3333));
    step(); w_req = 1'b0; tcdm_gnt = '0; #3;
    check("t3_rv",   BW'(w_r_valid), BW'(0));
    check("t3_busy", BW'(busy_o), BW'(0));
    step(); w_req = 1'b1; tcdm_gnt = 9'h1FE; #3;
    check("t3s_gnt0", BW'(w_gnt), BW'(0));
    step(); w_req = 1'b0; w_be = '0; w_data = '0; tcdm_gnt = 9'h001; #3;
    check("t3s_req",  BW'(tcdm_req), BW'(9'h001));
    check("t3s_be",   BW'(tcdm_be), BW'(36'h0F0F0F0F0));
    check("t3s_dat0", BW'(tcdm_data[31:0]), BW'(32'h1111_1111));
    check("t3s_gnt1", BW'(w_gnt), BW'(1));
    step(); tcdm_gnt = '0; #3;
    check("t3s_busy", BW'(busy_o), BW'(0));
    check("t3s_rv",   BW'(w_r_valid), BW'(0));

    // Back-to-back reads with random grant stalls, in-order scoreboard
    base = 32'h2000_0000; issued = 0; got = 0;
    w_wen = 1'b1;
    for (int c = 0; c < 600 && (issued < 6 || q.size() > 0); c++) begin
      step();
      w_req = (issued < 6); w_add = base; tcdm_gnt = 9'($urandom & $urandom);
      #3;
      if (w_r_valid) begin
        got++;
        if (q.size() == 0) check("b2b_extra", BW'(1), BW'(0));
        else               check("b2b_rdata", w_r_data, q.pop_front());
      end
      if (w_gnt && w_req) begin
        q.push_back(exp_rd(base));
        issued++;
        base = base + 32'h40;
      end
    end
    check("b2b_count", BW'(got), BW'(6));
    w_req = 1'b0; tcdm_gnt = '0;
    step(); #3;
    check("b2b_busy", BW'(busy_o), BW'(0));

    // Wrap-around base address
    base = 32'hFFFF_FFF0;
    step(); w_req = 1'b1; w_add = base; tcdm_gnt = 9'h1FF; #3;
    check("wrap_add3", BW'(tcdm_add[127:96]),  BW'(32'hFFFF_FFFC));
    check("wrap_add4", BW'(tcdm_add[159:128]), BW'(32'h0000_0000));
    check("wrap_add8", BW'(tcdm_add[287:256]), BW'(32'h0000_0010));
    step(); w_req = 1'b0; tcdm_gnt = '0; #3;
    check("wrap_rdata", w_r_data, exp_rd(base));

    // Reset in cycle 2 of a staggered read, then spurious response
    step(); w_req = 1'b1; w_add = 32'h3000_0000; tcdm_gnt = 9'h00F; #3;
    step(); w_req = 1'b0; tcdm_gnt = '0; #3;
    check("rr_busy", BW'(busy_o), BW'(1));
    step(); rst_ni = 1'b0; #3;
    check("rr_req_in_rst", BW'(tcdm_req), BW'(0));
    step(); rst_ni = 1'b1; #3;
    check("rr_req",   BW'(tcdm_req), BW'(0));
    check("rr_outs",  BW'({w_gnt, w_r_valid, busy_o, err_o}), BW'(0));
    check("rr_rdata", w_r_data, '0);
    step(); tcdm_r_valid = 9'h008; #3;
    check("sp_err_pre", BW'(err_o), BW'(0));
    check("sp_rv",      BW'(w_r_valid), BW'(0));
    step(); #3;
    check("sp_err", BW'(err_o), BW'(1));
    step(); step(); #3;
    check("sp_err_sticky", BW'(err_o), BW'(1));
    step(); rst_ni = 1'b0; step(); rst_ni = 1'b1; #3;
    check("sp_err_clr", BW'(err_o), BW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
